// File: rtl/ingress_pkg.sv
// Shared definitions for the ingress packet parser: header field layout,
// FSM state encoding and header decode helpers.
package ingress_pkg;

    // Header layout above the destination field (which is WIDTH_SEL bits wide)
    localparam int LEN_W     = 9;
    localparam int PRIO_W    = 3;
    localparam int PRIO_OFS  = 0;          // relative to WIDTH_SEL
    localparam int LEN_OFS   = PRIO_W;     // relative to WIDTH_SEL
    localparam int HDR_MAX_W = 64;         // widest header word the helpers accept

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } state_t;

    // Payload length field of a header word whose destination field is sel_w bits wide.
    function automatic logic [LEN_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] data,
                                                 input int unsigned          sel_w);
        logic [HDR_MAX_W-1:0] shifted;
        shifted = data >> (sel_w + LEN_OFS);
        return shifted[LEN_W-1:0];
    endfunction

    // Priority field of a header word whose destination field is sel_w bits wide.
    function automatic logic [PRIO_W-1:0] hdr_prio(input logic [HDR_MAX_W-1:0] data,
                                                   input int unsigned          sel_w);
        logic [HDR_MAX_W-1:0] shifted;
        shifted = data >> (sel_w + PRIO_OFS);
        return shifted[PRIO_W-1:0];
    endfunction

endpackage

// File: rtl/ingress_packet_parser_if.sv
// Word stream into the parser (wr_*) and the tagged stream it forwards (out_*).
interface ingress_packet_parser_if #(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH_SEL  = 3
);
    import ingress_pkg::*;

    logic                  wr_sop;
    logic                  wr_eop;
    logic                  wr_vld;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  out_vld;
    logic                  out_sop;
    logic                  out_eop;
    logic                  out_err;
    logic [DATA_WIDTH-1:0] out_data;
    logic [WIDTH_SEL-1:0]  out_dest;
    logic [WIDTH_SEL-1:0]  out_src;
    logic [PRIO_W-1:0]     out_prio;

    // Packet source / consumer of the forwarded stream
    modport master (
        output wr_sop, wr_eop, wr_vld, wr_data,
        input  out_vld, out_sop, out_eop, out_err, out_data, out_dest, out_src, out_prio
    );

    // The parser itself
    modport slave (
        input  wr_sop, wr_eop, wr_vld, wr_data,
        output out_vld, out_sop, out_eop, out_err, out_data, out_dest, out_src, out_prio
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    // Count up on inc until the counter reaches its maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: registers are written with <= so every flop samples pre-edge values.
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/ingress_packet_parser.sv
// Per-port ingress parser: decodes the SOP header, checks framing against the
// header length, forwards good words one cycle later tagged with dest/src/prio,
// and counts good packets, refused packets and framing errors.
module ingress_packet_parser
    import ingress_pkg::*;
#(
    parameter int PORT_NUB_TOTAL = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ingress_packet_parser_if.slave bus,
    input  logic [WIDTH_SEL-1:0]  local_port_info,
    input  logic                  full,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remain_q, remain_d;

    // Per-word decisions made in the current cycle, registered onto out_*
    logic               fwd;
    logic               fwd_sop;
    logic               fwd_eop;
    logic               fwd_err;
    logic               latch_hdr;
    logic               inc_pkt;
    logic               inc_drop;
    logic               inc_err;

    // Header fields of the current input word (only meaningful on SOP)
    logic [LEN_W-1:0]     hdr_len_w;
    logic [PRIO_W-1:0]    hdr_prio_w;
    logic [WIDTH_SEL-1:0] hdr_dest_w;

    assign hdr_len_w  = hdr_len(HDR_MAX_W'(bus.wr_data), WIDTH_SEL);
    assign hdr_prio_w = hdr_prio(HDR_MAX_W'(bus.wr_data), WIDTH_SEL);
    assign hdr_dest_w = bus.wr_data[WIDTH_SEL-1:0];

    // FSM state and outstanding payload word count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Next state, remaining-count update and per-word forward/count decisions
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        remain_d  = remain_q;
        fwd       = 1'b0;
        fwd_sop   = 1'b0;
        fwd_eop   = 1'b0;
        fwd_err   = 1'b0;
        latch_hdr = 1'b0;
        inc_pkt   = 1'b0;
        inc_drop  = 1'b0;
        inc_err   = 1'b0;

        if (bus.wr_vld) begin
            case (state_q)
                IDLE: begin
                    if (!bus.wr_sop) begin
                        // Stray word outside any packet
                        inc_err = 1'b1;
                    end else if (full) begin
                        // Switch refuses the packet; full wins over a bad length
                        inc_drop = 1'b1;
                        state_d  = bus.wr_eop ? IDLE : DROP;
                    end else if ((hdr_len_w == '0) || bus.wr_eop) begin
                        // Header-only or zero-length packet is malformed
                        inc_err = 1'b1;
                        state_d = bus.wr_eop ? IDLE : DROP;
                    end else begin
                        fwd       = 1'b1;
                        fwd_sop   = 1'b1;
                        latch_hdr = 1'b1;
                        remain_d  = hdr_len_w;
                        state_d   = PASS;
                    end
                end

                PASS: begin
                    fwd      = 1'b1;
                    remain_d = remain_q - LEN_W'(1);
                    if (bus.wr_sop) begin
                        // Truncated packet: this word closes it, the new packet is lost
                        fwd_eop  = 1'b1;
                        fwd_err  = 1'b1;
                        inc_err  = 1'b1;
                        remain_d = '0;
                        state_d  = bus.wr_eop ? IDLE : DROP;
                    end else if (remain_q == LEN_W'(1)) begin
                        fwd_eop = 1'b1;
                        if (bus.wr_eop) begin
                            inc_pkt = 1'b1;
                            state_d = IDLE;
                        end else begin
                            // Overlong packet: close it here, discard the tail
                            fwd_err = 1'b1;
                            inc_err = 1'b1;
                            state_d = DROP;
                        end
                    end else if (bus.wr_eop) begin
                        // Early EOP
                        fwd_eop  = 1'b1;
                        fwd_err  = 1'b1;
                        inc_err  = 1'b1;
                        remain_d = '0;
                        state_d  = IDLE;
                    end
                end

                DROP: begin
                    if (bus.wr_eop) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d  = IDLE;
                    remain_d = '0;
                end
            endcase
        end
    end

    // Registered forwarded word, framing and header tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_vld  <= 1'b0;
            bus.out_sop  <= 1'b0;
            bus.out_eop  <= 1'b0;
            bus.out_err  <= 1'b0;
            bus.out_data <= '0;
            bus.out_dest <= '0;
            bus.out_src  <= '0;
            bus.out_prio <= '0;
        end else begin
            bus.out_vld  <= fwd;
            bus.out_sop  <= fwd_sop;
            bus.out_eop  <= fwd_eop;
            bus.out_err  <= fwd_err;
            bus.out_data <= fwd ? bus.wr_data : '0;
            if (latch_hdr) begin
                bus.out_dest <= hdr_dest_w;
                bus.out_src  <= local_port_info;
                bus.out_prio <= hdr_prio_w;
            end
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_pkt),
        .cnt   (pkt_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_drop),
        .cnt   (drop_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_err),
        .cnt   (err_cnt)
    );

endmodule

// File: tb/tb_ingress_packet_parser.sv
// Bench for ingress_packet_parser: directed vector table, hand-written reset
// and maximum-length sequences, then random traffic against a word-level model.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_ingress_packet_parser;

    localparam int DW  = 16;
    localparam int WS  = 3;
    localparam int CW  = 16;
    localparam int CWS = 4;
    localparam logic [WS-1:0] LOCAL = 3'd3;

    logic clk;
    logic rst_n;
    logic full;

    logic [CW-1:0]  pkt_cnt, drop_cnt, err_cnt;
    logic [CWS-1:0] pkt_cnt_s, drop_cnt_s, err_cnt_s;

    ingress_packet_parser_if #(.DATA_WIDTH(DW), .WIDTH_SEL(WS)) bus_a ();
    ingress_packet_parser_if #(.DATA_WIDTH(DW), .WIDTH_SEL(WS)) bus_b ();

    assign bus_b.wr_vld  = bus_a.wr_vld;
    assign bus_b.wr_sop  = bus_a.wr_sop;
    assign bus_b.wr_eop  = bus_a.wr_eop;
    assign bus_b.wr_data = bus_a.wr_data;

    ingress_packet_parser #(.PORT_NUB_TOTAL(8), .DATA_WIDTH(DW), .WIDTH_SEL(WS), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus_a),
        .local_port_info (LOCAL),
        .full            (full),
        .pkt_cnt         (pkt_cnt),
        .drop_cnt        (drop_cnt),
        .err_cnt         (err_cnt)
    );

    ingress_packet_parser #(.PORT_NUB_TOTAL(8), .DATA_WIDTH(DW), .WIDTH_SEL(WS), .CNT_WIDTH(CWS)) dut_small (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus_b),
        .local_port_info (LOCAL),
        .full            (full),
        .pkt_cnt         (pkt_cnt_s),
        .drop_cnt        (drop_cnt_s),
        .err_cnt         (err_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] hdr(input int dest, input int prio, input int len);
        logic [8:0] l;
        logic [2:0] p;
        logic [2:0] d;
        l = len[8:0];
        p = prio[2:0];
        d = dest[2:0];
        return {1'b0, l, p, d};
    endfunction

    // ---------------- reference model (word level, from the framing rules) ----------------
    bit          m_in_pkt;
    bit          m_skip;
    int          m_left;
    int          m_pkt, m_drop, m_err;
    logic [2:0]  m_dest, m_src, m_prio;
    bit          e_vld, e_sop, e_eop, e_err;
    logic [DW-1:0] e_data;

    task automatic model_reset();
        m_in_pkt = 0; m_skip = 0; m_left = 0;
        m_pkt = 0; m_drop = 0; m_err = 0;
        m_dest = '0; m_src = '0; m_prio = '0;
        e_vld = 0; e_sop = 0; e_eop = 0; e_err = 0; e_data = '0;
    endtask

    task automatic model_step(input bit vld, input bit sop, input bit eop,
                              input logic [DW-1:0] data, input bit fl);
        int len;
        e_vld = 0; e_sop = 0; e_eop = 0; e_err = 0; e_data = '0;
        if (!vld) return;
        if (m_skip) begin
            if (eop) m_skip = 0;
            return;
        end
        if (!m_in_pkt) begin
            if (!sop) begin m_err++; return; end
            if (fl) begin m_drop++; m_skip = !eop; return; end
            len = int'(data[14:6]);
            if (len == 0 || eop) begin m_err++; m_skip = !eop; return; end
            e_vld = 1; e_sop = 1; e_data = data;
            m_dest = data[2:0]; m_prio = data[5:3]; m_src = LOCAL;
            m_left = len; m_in_pkt = 1;
            return;
        end
        e_vld = 1; e_data = data;
        m_left--;
        if (sop) begin
            e_eop = 1; e_err = 1; m_err++; m_in_pkt = 0; m_skip = !eop;
        end else if (m_left == 0) begin
            e_eop = 1; m_in_pkt = 0;
            if (eop) m_pkt++;
            else begin e_err = 1; m_err++; m_skip = 1; end
        end else if (eop) begin
            e_eop = 1; e_err = 1; m_err++; m_in_pkt = 0;
        end
    endtask

    function automatic logic [CW-1:0] sat_w(input int v);
        return (v > 65535) ? 16'hFFFF : v[CW-1:0];
    endfunction

    function automatic logic [CWS-1:0] sat_s(input int v);
        return (v > 15) ? 4'hF : v[CWS-1:0];
    endfunction

    task automatic compare_outputs();
        check("frame", {bus_a.out_vld, bus_a.out_sop, bus_a.out_eop, bus_a.out_err},
                       {e_vld, e_sop, e_eop, e_err});
        if (e_vld)
            check("word_tags", {bus_a.out_data, bus_a.out_dest, bus_a.out_src, bus_a.out_prio},
                               {e_data, m_dest, m_src, m_prio});
        check("counters", {pkt_cnt, drop_cnt, err_cnt}, {sat_w(m_pkt), sat_w(m_drop), sat_w(m_err)});
        check("small_inst", {bus_b.out_vld, bus_b.out_eop, bus_b.out_err, pkt_cnt_s, drop_cnt_s, err_cnt_s},
                            {e_vld, e_eop, e_err, sat_s(m_pkt), sat_s(m_drop), sat_s(m_err)});
    endtask

    // One input cycle: drive on the falling edge, sample 1 time unit after the rising edge
    task automatic cycle(input bit vld, input bit sop, input bit eop,
                         input logic [DW-1:0] data, input bit fl);
        @(negedge clk);
        bus_a.wr_vld  = vld;
        bus_a.wr_sop  = sop;
        bus_a.wr_eop  = eop;
        bus_a.wr_data = data;
        full          = fl;
        model_step(vld, sop, eop, data, fl);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            vld, sop, eop, fl;
        logic [DW-1:0] data;
        bit            ev, es, ee, er;
        logic [2:0]    edest, eprio;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    int base_pkt;

    initial begin
        bus_a.wr_vld = 0; bus_a.wr_sop = 0; bus_a.wr_eop = 0; bus_a.wr_data = '0;
        full = 0;
        rst_n = 0;
        model_reset();

        vecs = '{
            // good packet dest=5 prio=2 len=3 with a gap
            '{1,1,0,0, hdr(5,2,3),  1,1,0,0, 3'd5,3'd2},
            '{1,0,0,0, 16'h1111,    1,0,0,0, 3'd5,3'd2},
            '{0,1,1,0, 16'hDEAD,    0,0,0,0, 3'd5,3'd2},
            '{1,0,0,0, 16'h2222,    1,0,0,0, 3'd5,3'd2},
            '{1,0,1,0, 16'h3333,    1,0,1,0, 3'd5,3'd2},
            // full at SOP, full drops on word 2: whole packet dropped
            '{1,1,0,1, hdr(1,0,4),  0,0,0,0, 3'd0,3'd0},
            '{1,0,0,0, 16'h4444,    0,0,0,0, 3'd0,3'd0},
            '{1,0,0,0, 16'h5555,    0,0,0,0, 3'd0,3'd0},
            '{1,0,0,1, 16'h6666,    0,0,0,0, 3'd0,3'd0},
            '{1,0,1,0, 16'h7777,    0,0,0,0, 3'd0,3'd0},
            // next packet passes (minimum length 1)
            '{1,1,0,0, hdr(2,7,1),  1,1,0,0, 3'd2,3'd7},
            '{1,0,1,0, 16'h8888,    1,0,1,0, 3'd2,3'd7},
            // len=4, EOP on word 3 (early)
            '{1,1,0,0, hdr(3,1,4),  1,1,0,0, 3'd3,3'd1},
            '{1,0,0,0, 16'h0A0A,    1,0,0,0, 3'd3,3'd1},
            '{1,0,1,0, 16'h0B0B,    1,0,1,1, 3'd3,3'd1},
            // len=2, EOP on word 5 (overlong)
            '{1,1,0,0, hdr(4,3,2),  1,1,0,0, 3'd4,3'd3},
            '{1,0,0,0, 16'h0C0C,    1,0,0,0, 3'd4,3'd3},
            '{1,0,0,0, 16'h0D0D,    1,0,1,1, 3'd4,3'd3},
            '{1,0,0,0, 16'h0E0E,    0,0,0,0, 3'd4,3'd3},
            '{1,0,1,0, 16'h0F0F,    0,0,0,0, 3'd4,3'd3},
            // len=5, new SOP at payload word 2 (truncated)
            '{1,1,0,0, hdr(6,4,5),  1,1,0,0, 3'd6,3'd4},
            '{1,0,0,0, 16'h1212,    1,0,0,0, 3'd6,3'd4},
            '{1,1,0,0, hdr(7,0,2),  1,0,1,1, 3'd6,3'd4},
            '{1,0,0,0, 16'h1313,    0,0,0,0, 3'd6,3'd4},
            '{1,0,1,0, 16'h1414,    0,0,0,0, 3'd6,3'd4},
            // len=0 single-word header, then a stray word in IDLE
            '{1,1,1,0, hdr(0,0,0),  0,0,0,0, 3'd0,3'd0},
            '{1,0,0,0, 16'h9999,    0,0,0,0, 3'd0,3'd0},
            // full together with len=0: counted as a drop only
            '{1,1,1,1, hdr(1,1,0),  0,0,0,0, 3'd0,3'd0},
            // full ignored after SOP: len=1 packet with full on its EOP word
            '{1,1,0,0, hdr(1,1,1),  1,1,0,0, 3'd1,3'd1},
            '{1,0,1,1, 16'hABCD,    1,0,1,0, 3'd1,3'd1}
        };

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus_a.out_vld, bus_a.out_sop, bus_a.out_eop, bus_a.out_err,
                                bus_a.out_data, bus_a.out_dest, bus_a.out_src, bus_a.out_prio}, 64'd0);
        check("reset_counters", {pkt_cnt, drop_cnt, err_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1;

        // Directed table
        for (int i = 0; i < NV; i++) begin
            cycle(vecs[i].vld, vecs[i].sop, vecs[i].eop, vecs[i].data, vecs[i].fl);
            check($sformatf("vec%0d_frame", i),
                  {bus_a.out_vld, bus_a.out_sop, bus_a.out_eop, bus_a.out_err},
                  {vecs[i].ev, vecs[i].es, vecs[i].ee, vecs[i].er});
            if (vecs[i].ev)
                check($sformatf("vec%0d_tags", i), {bus_a.out_dest, bus_a.out_src, bus_a.out_prio},
                      {vecs[i].edest, LOCAL, vecs[i].eprio});
        end
        check("table_pkt_cnt",  pkt_cnt,  16'd3);
        check("table_drop_cnt", drop_cnt, 16'd2);
        check("table_err_cnt",  err_cnt,  16'd5);

        // Asynchronous reset mid-PASS
        cycle(1, 1, 0, hdr(1, 1, 4), 0);
        cycle(1, 0, 0, 16'h5A5A, 0);
        #1;
        rst_n = 0;
        model_reset();
        #1;
        check("async_rst_outputs", {bus_a.out_vld, bus_a.out_sop, bus_a.out_eop, bus_a.out_err,
                                    bus_a.out_data, bus_a.out_dest, bus_a.out_src, bus_a.out_prio}, 64'd0);
        check("async_rst_counters", {pkt_cnt, drop_cnt, err_cnt}, 64'd0);
        #1;
        rst_n = 1;
        cycle(1, 0, 0, 16'h6B6B, 0);
        cycle(1, 0, 0, 16'h7C7C, 0);
        cycle(1, 0, 1, 16'h8D8D, 0);
        check("post_rst_err_cnt", err_cnt, 16'd3);
        cycle(1, 1, 0, hdr(2, 5, 2), 0);
        cycle(1, 0, 0, 16'h1010, 0);
        cycle(1, 0, 1, 16'h2020, 0);
        check("post_rst_pkt_cnt", pkt_cnt, 16'd1);

        // Maximum length packet
        base_pkt = m_pkt;
        cycle(1, 1, 0, hdr(4, 6, 511), 0);
        for (int i = 1; i <= 511; i++)
            cycle(1, 0, (i == 511), DW'($urandom), 0);
        check("len511_pkt_cnt", pkt_cnt, sat_w(base_pkt + 1));

        // Random traffic
        for (int p = 0; p < 400; p++) begin
            int  kind;
            int  len;
            int  nwords;
            int  cut;
            logic [DW-1:0] w[$];
            bit  s[$];
            bit  e[$];
            kind = $urandom_range(0, 9);
            len  = (kind == 9) ? 0 : $urandom_range(1, 6);
            nwords = len + 1;
            w.delete(); s.delete(); e.delete();
            w.push_back(hdr($urandom_range(0, 7), $urandom_range(0, 7), len));
            s.push_back(1); e.push_back(0);
            for (int k = 1; k < nwords; k++) begin
                w.push_back(DW'($urandom) & 16'h803F); s.push_back(0); e.push_back(0);
            end
            if (kind == 7) begin
                cut = $urandom_range(1, 3);
                for (int k = 0; k < cut; k++) begin
                    w.push_back(DW'($urandom)); s.push_back(0); e.push_back(0);
                end
            end
            e[e.size() - 1] = 1;
            if (kind == 6 && len >= 2) begin
                cut = $urandom_range(1, len - 1);
                while (e.size() > cut + 1) begin void'(w.pop_back()); void'(s.pop_back()); void'(e.pop_back()); end
                e[cut] = 1;
            end
            if (kind == 8 && len >= 2) begin
                cut = $urandom_range(1, len - 1);
                s[cut] = 1;
                e[cut] = $urandom_range(0, 1);
            end
            if (kind == 9 && $urandom_range(0, 1) == 1) s[0] = 0;
            if (kind == 0) e[0] = 1;
            for (int k = 0; k < w.size(); k++) begin
                if ($urandom_range(0, 4) == 0)
                    cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), DW'($urandom), $urandom_range(0, 1));
                if (k == 0)
                    cycle(1, s[k], e[k], w[k], (kind == 5) || ($urandom_range(0, 15) == 0));
                else
                    cycle(1, s[k], e[k], w[k], $urandom_range(0, 1));
            end
        end

        check("final_counters", {pkt_cnt, drop_cnt, err_cnt}, {sat_w(m_pkt), sat_w(m_drop), sat_w(m_err)});
        check("small_err_saturated", err_cnt_s, sat_s(m_err));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ingress_packet_parser.md
# ingress_packet_parser

Per-port ingress stage that sits directly upstream of the shared-memory switch write side, one instance per input port. It decodes the header word of each packet arriving on the `wr_*` interface and checks packet framing against the header length. It forwards well-formed packets, tagged with destination, source and priority, one cycle later. Packets refused because the switch reports `full` at start-of-packet, and packets with framing errors, are dropped or closed with an error flag, and both events are counted.

## Interface
Parameters:
- `PORT_NUB_TOTAL`, default 8: number of switch ports.
- `DATA_WIDTH`, default 16: word width. Must be ≥ `WIDTH_SEL`+3+9.
- `WIDTH_SEL`, default `$clog2(PORT_NUB_TOTAL)`: width of the port index.
- `CNT_WIDTH`, default 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_sop` in 1: start of packet, qualified by `wr_vld`.
- `wr_eop` in 1: end of packet, qualified by `wr_vld`.
- `wr_vld` in 1: input word valid.
- `wr_data` in `DATA_WIDTH`: input word.
- `local_port_info` in `WIDTH_SEL`: this port's index, static.
- `full` in 1: switch cannot accept a new packet. Sampled only at SOP.
- `out_vld`, `out_sop`, `out_eop` out 1 each: forwarded framing.
- `out_data` out `DATA_WIDTH`: forwarded word.
- `out_dest` out `WIDTH_SEL`: destination port.
- `out_src` out `WIDTH_SEL`: source port.
- `out_prio` out 3: packet priority.
- `out_err` out 1: the word carrying `out_eop` closes a malformed packet; downstream discards that packet.
- `pkt_cnt`, `drop_cnt`, `err_cnt` out `CNT_WIDTH` each: saturating statistics counters.

## Operation
- Header is the SOP word:
  - `[WIDTH_SEL-1:0]` = dest.
  - `[WIDTH_SEL+2:WIDTH_SEL]` = prio.
  - `[WIDTH_SEL+11:WIDTH_SEL+3]` = `len`, the number of payload words after the header, 9 bits, valid range 1..511.
  - A packet is therefore `len`+1 words long, with EOP on the last word.
- The header word itself is forwarded, with `out_sop`=1.
- `out_dest`, `out_src` and `out_prio` are latched at SOP and held constant for the whole forwarded packet.
- FSM has three states: IDLE, PASS, DROP. A counter `remain` (9 bits) tracks outstanding payload words.
- IDLE:
  - `wr_vld`&`wr_sop`, `len`≠0, `full`=0, `wr_eop`=0: forward the header, load `remain`=`len`, go to PASS.
  - `wr_vld`&`wr_sop` with `full`=1: nothing forwarded, `drop_cnt`++. Go to DROP, or stay in IDLE if `wr_eop` is also set.
  - `wr_vld`&`wr_sop` with `len`=0 or `wr_eop`=1 (single-word packet): nothing forwarded, `err_cnt`++. Go to DROP unless `wr_eop` is set.
  - `wr_vld` without `wr_sop`: word discarded, `err_cnt`++, stay in IDLE.
  - `full` takes precedence over the `len`=0 check, so only `drop_cnt` increments.
- PASS, on each `wr_vld`:
  - Forward the word and decrement `remain`.
  - `remain`=1 and `wr_eop`: `out_eop`=1, `pkt_cnt`++, go to IDLE.
  - `remain`>1 and `wr_eop` (early EOP): `out_eop`=1, `out_err`=1, `err_cnt`++, go to IDLE.
  - `remain`=1 and no `wr_eop` (overlong packet): forced `out_eop`=1, `out_err`=1, `err_cnt`++, go to DROP.
  - `wr_sop` in PASS (truncated packet): the word is forwarded as the closing word with `out_eop`=1, `out_err`=1, `err_cnt`++. Go to DROP, or to IDLE if `wr_eop` is also set. The new packet is lost.
- DROP: discard every word until `wr_vld`&`wr_eop`, then go to IDLE. No counting in DROP.
- `full` is ignored after SOP. The switch guarantees headroom for one maximum-size packet after it deasserts `full`.
- All counters saturate at all-ones and never wrap.

## Timing
- Latency is exactly 1 cycle from input word to output word. All outputs are registered. There is no backpressure toward the source.
- `out_vld`, `out_sop`, `out_eop` and `out_err` are single-cycle, one per accepted input word.
- `out_err` is only ever 1 together with `out_eop`.
- Gaps with `wr_vld`=0 are allowed anywhere. The FSM and `remain` hold during a gap, and `out_vld`=0 that cycle.
- Reset values: all outputs 0, FSM in IDLE, `remain`=0, counters 0.
- Reset asserted mid-packet clears everything immediately. No closing EOP is emitted. After reset, input words before the next SOP fall under the IDLE no-SOP rule.
- `pkt_cnt`, `drop_cnt` and `err_cnt` update in the same cycle the corresponding output word is registered.

## Structure
- Shared package `ingress_pkg`:
  - header field offsets and widths (`LEN_W`=9, `PRIO_W`=3);
  - state enum `{IDLE, PASS, DROP}`;
  - a function `hdr_len(data)`.
- One natural sub-module, `sat_counter` (parameter `CNT_WIDTH`; ports `inc`, `cnt`), instantiated three times.

## Test plan
- Header dest=5, prio=2, len=3, then 3 payload words, EOP on word 4, `full`=0 → 4 output words 1 cycle later. `out_sop` on word 1, `out_eop` on word 4, `out_dest`=5, `out_src`=`local_port_info`, `out_prio`=2, `pkt_cnt`=1.
- `full`=1 at SOP of a len=4 packet; `full` drops to 0 on word 2 → no output for the whole packet, `drop_cnt`=1. The next packet passes.
- len=4 with EOP on word 3 → 3 words out, word 3 has `out_eop`=`out_err`=1, `err_cnt`=1. len=2 with EOP on word 5 → 3 words out, word 3 has forced EOP with error, words 4–5 dropped.
- New SOP at payload word 2 of a len=5 packet → that word is emitted with `out_eop`=`out_err`=1; input discarded until the next `wr_eop`; `err_cnt`=1.
- len=0 header, then a stray non-SOP word in IDLE → no output, `err_cnt`=2. Preload `err_cnt` near max and force errors → `err_cnt` holds at 0xFFFF.
- `rst_n` pulsed low mid-PASS for 1 cycle → outputs 0 asynchronously. Remaining old words count as IDLE errors; a fresh packet then forwards normally.
